// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-train decoder: FSM encoding and the
// default timing constants inherited from the auto-repeat generator.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    REPEAT = 2'b10
  } state_t;

  // Auto-repeat generator walls: slowest and fastest repeat interval.
  localparam int MAX_WALL       = 100_000_000;
  localparam int MIN_WALL       = 1_000_000;
  // Extra slack so the slowest legal repeat never looks like a timeout.
  localparam int TIMEOUT_MARGIN = 1_000;

  localparam int DEF_TIMEOUT = MAX_WALL + TIMEOUT_MARGIN;
  localparam int DEF_MIN_GAP = MIN_WALL;
  localparam int DEF_CNT_W   = 27;
  localparam int DEF_COUNT_W = 8;

endpackage

// File: rtl/pulse_train_decoder_if.sv
// Bus between the pulse source (master) and the decoder (slave).
// Protocol: no backpressure. pulse is a free-running input; gap_valid and
// burst_done are one-cycle strobes; last_gap/accel are meaningful in the
// cycle gap_valid is high and hold until the next gap_valid; level, count
// and glitch are plain registered levels.
interface pulse_train_decoder_if #(
  parameter int CNT_W   = 27,
  parameter int COUNT_W = 8
);
  logic               pulse;
  logic               level;
  logic [COUNT_W-1:0] count;
  logic [CNT_W-1:0]   last_gap;
  logic               gap_valid;
  logic               accel;
  logic               glitch;
  logic               burst_done;

  modport master (
    output pulse,
    input  level, count, last_gap, gap_valid, accel, glitch, burst_done
  );

  modport slave (
    input  pulse,
    output level, count, last_gap, gap_valid, accel, glitch, burst_done
  );
endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: one registered sample, combinational edge output.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_d;

  // Previous sample of the input; resets low so a level already high at
  // reset release produces one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_d <= 1'b0;
    else     in_d <= in;
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/pulse_train_decoder.sv
// Reconstructs the held level behind an auto-repeat pulse train: measures
// inter-pulse gaps, counts pulses per burst, flags acceleration, glitches
// and burst end.
module pulse_train_decoder
  import pulse_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int COUNT_W = DEF_COUNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int MIN_GAP = DEF_MIN_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  pulse_train_decoder_if.slave  bus,
  output state_t                dbg_state
);

  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   MIN_GAP_C = CNT_W'(MIN_GAP);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic ev;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_n;
  logic               level_q, level_n;
  logic [COUNT_W-1:0] count_q, count_n;
  logic [CNT_W-1:0]   last_gap_q, last_gap_n;
  logic               gap_valid_q, gap_valid_n;
  logic               accel_q, accel_n;
  logic               glitch_q, glitch_n;
  logic               burst_done_q, burst_done_n;
  logic [CNT_W-1:0]   gap;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .in   (bus.pulse),
    .rise (ev)
  );

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      level_q      <= 1'b0;
      count_q      <= '0;
      last_gap_q   <= '0;
      gap_valid_q  <= 1'b0;
      accel_q      <= 1'b0;
      glitch_q     <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      gap_cnt_q    <= gap_cnt_n;
      level_q      <= level_n;
      count_q      <= count_n;
      last_gap_q   <= last_gap_n;
      gap_valid_q  <= gap_valid_n;
      accel_q      <= accel_n;
      glitch_q     <= glitch_n;
      burst_done_q <= burst_done_n;
    end
  end

  // Next-state and next-output logic; an event always beats the timeout.
  always_comb begin
    state_n      = state_q;
    gap_cnt_n    = gap_cnt_q;
    level_n      = level_q;
    count_n      = count_q;
    last_gap_n   = last_gap_q;
    accel_n      = accel_q;
    glitch_n     = glitch_q;
    gap_valid_n  = 1'b0;
    burst_done_n = 1'b0;
    // Distance from the previous event if an event lands this edge.
    gap          = gap_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (ev) begin
          state_n   = ARMED;
          level_n   = 1'b1;
          count_n   = COUNT_W'(1);
          glitch_n  = 1'b0;
          gap_cnt_n = '0;
        end
      end
      ARMED, REPEAT: begin
        if (ev) begin
          state_n     = REPEAT;
          last_gap_n  = gap;
          gap_valid_n = 1'b1;
          count_n     = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
          gap_cnt_n   = '0;
          accel_n     = (state_q == REPEAT) && (gap < last_gap_q);
          if (gap < MIN_GAP_C) glitch_n = 1'b1;
        end else if (gap_cnt_q == TO_LAST) begin
          state_n      = IDLE;
          level_n      = 1'b0;
          burst_done_n = 1'b1;
          gap_cnt_n    = '0;
        end else begin
          gap_cnt_n = gap;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.level      = level_q;
  assign bus.count      = count_q;
  assign bus.last_gap   = last_gap_q;
  assign bus.gap_valid  = gap_valid_q;
  assign bus.accel      = accel_q;
  assign bus.glitch     = glitch_q;
  assign bus.burst_done = burst_done_q;
  assign dbg_state      = state_q;

endmodule
